// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision sequential adder.
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mp_state_e;

  localparam int CHUNK_W = 16;

  // Chunk index width; a single-chunk design still needs one bit.
  function automatic int idx_w(input int words);
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/cla_add16.sv
// Combinational 16-bit carry-lookahead adder with every carry written
// out as a flat generate/propagate sum of products.
module cla_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g, p;
  logic [16:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = cin&p[0..i] | OR_j g[j]&p[j+1..i]: no ripple through c[i].
  always_comb begin
    logic acc, t;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < 16; i++) begin
      t = cin;
      for (int k = 0; k <= i; k++) t = t & p[k];
      acc = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int k = j + 1; k <= i; k++) t = t & p[k];
        acc = acc | t;
      end
      c[i+1] = acc;
    end
  end

  assign sum  = p ^ c[15:0];
  assign cout = c[16];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract, one 16-bit chunk per cycle LS-first through
// a single CLA, carry chained through a register.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int W     = CHUNK_W,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W*WORDS-1:0]   a,
  input  logic [W*WORDS-1:0]   b,
  input  logic                 cin,
  input  logic                 op_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int N  = W * WORDS;
  localparam int IW = idx_w(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  mp_state_e     state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [N-1:0]  a_q, b_q;  // b_q already holds b_eff (b or ~b)

  logic [W-1:0]  a_ch, b_ch, s_ch;
  logic          c_out;

  assign a_ch = a_q[int'(idx)*W +: W];
  assign b_ch = b_q[int'(idx)*W +: W];

  cla_add16 u_cla (
    .a    (a_ch),
    .b    (b_ch),
    .cin  (carry),
    .sum  (s_ch),
    .cout (c_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= op_sub ? ~b : b;
            carry    <= op_sub ? 1'b1 : cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[int'(idx)*W +: W] <= s_ch;
          carry                 <= c_out;
          if (idx == LAST) begin
            idx       <= '0;
            cout      <= c_out;
            // Operand sign bits agree but the result sign differs.
            ovf       <= (a_q[N-1] == b_q[N-1]) && (s_ch[W-1] != a_q[N-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (WORDS=4): directed corner cases plus
// randomized operations against a wide-integer arithmetic model.
module tb_mp_add_seq;

  localparam int WORDS = 4;
  localparam int N = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [N-1:0] a, b;
  logic         cin, op_sub;
  logic         out_valid, out_ready;
  logic [N-1:0] sum;
  logic         cout, ovf;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.W(16), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // Reference: exact unsigned and signed arithmetic on wider integers.
  task automatic model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                       input logic mci, input logic msub,
                       output logic [N-1:0] es, output logic ec, output logic eo);
    logic [N:0]          u;
    logic signed [N+1:0] sa, sb, e;
    sa = $signed({{2{ma[N-1]}}, ma});
    sb = $signed({{2{mb[N-1]}}, mb});
    if (msub) begin
      u  = {1'b0, ma} - {1'b0, mb};
      ec = (ma >= mb);
      e  = sa - sb;
    end else begin
      u  = {1'b0, ma} + {1'b0, mb} + {{N{1'b0}}, mci};
      ec = u[N];
      e  = sa + sb + $signed({{(N+1){1'b0}}, mci});
    end
    es = u[N-1:0];
    eo = (e[N+1:N-1] != 3'b000) && (e[N+1:N-1] != 3'b111);
  endtask

  // Drives one accept, returns outputs and edges-to-out_valid; leaves DONE pending.
  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib,
                       input logic ici, input logic isub, output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    a = ia; b = ib; cin = ici; op_sub = isub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom(); b = $urandom();
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [N-1:0] ia, input logic [N-1:0] ib,
                          input logic ici, input logic isub);
    logic [N-1:0] es; logic ec, eo; int lat;
    model(ia, ib, ici, isub, es, ec, eo);
    issue(ia, ib, ici, isub, lat);
    total++;
    if (lat !== WORDS) $display("FAIL %s latency got %0d want %0d", name, lat, WORDS);
    else pass_cnt++;
    total++;
    if ({sum, cout, ovf} !== {es, ec, eo})
      $display("FAIL %s result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               name, sum, cout, ovf, es, ec, eo);
    else pass_cnt++;
    retire();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
    #12;
    total++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, {N{1'b0}}, 1'b0, 1'b0})
      $display("FAIL reset got in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b want 1 0 0 0 0",
               in_ready, out_valid, sum, cout, ovf);
    else pass_cnt++;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_directed();
    check_op("carry_chunks", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    total++;
    if (sum !== 64'h0000_0000_0001_0000)
      $display("FAIL carry_chunks_const got %h want %h", sum, 64'h0000_0000_0001_0000);
    else pass_cnt++;
    check_op("full_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    total++;
    if ({sum, cout, ovf} !== {64'h0, 1'b1, 1'b0})
      $display("FAIL full_wrap_const got %h/%b/%b want 0/1/0", sum, cout, ovf);
    else pass_cnt++;
    check_op("wrap_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    check_op("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    total++;
    if ({sum, cout, ovf} !== {64'h8000_0000_0000_0000, 1'b0, 1'b1})
      $display("FAIL signed_ovf_const got %h/%b/%b want 8000000000000000/0/1", sum, cout, ovf);
    else pass_cnt++;
    check_op("sub_borrow", 64'd5, 64'd10, 1'b1, 1'b1);
    total++;
    if ({sum, cout, ovf} !== {64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0})
      $display("FAIL sub_borrow_const got %h/%b/%b want fffffffffffffffb/0/0", sum, cout, ovf);
    else pass_cnt++;
    check_op("sub_noborrow", 64'd10, 64'd5, 1'b0, 1'b1);
    check_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [N-1:0] es, s0; logic ec, eo; int lat;
    model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, es, ec, eo);
    issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, lat);
    s0 = sum;
    for (int i = 0; i < 3; i++) begin
      a = $urandom(); b = $urandom(); op_sub = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++;
      if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, es, ec, eo} || sum !== s0)
        $display("FAIL bp_hold cyc%0d got ov=%b ir=%b sum=%h cout=%b ovf=%b want 1 0 %h %b %b",
                 i, out_valid, in_ready, sum, cout, ovf, es, ec, eo);
      else pass_cnt++;
    end
    retire();
    total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL bp_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    else pass_cnt++;
    check_op("after_bp", 64'd77, 64'd23, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    total++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, {N{1'b0}}, 1'b0, 1'b0})
      $display("FAIL reset_mid_run got in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b want 1 0 0 0 0",
               in_ready, out_valid, sum, cout, ovf);
    else pass_cnt++;
    @(posedge clk); #1; rst = 1'b0;
    check_op("post_reset", 64'd1000, 64'd2001, 1'b0, 1'b0);
    total++;
    if (sum !== 64'd3001) $display("FAIL post_reset_const got %0d want 3001", sum);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] ra, rb;
    for (int i = 0; i < 24; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if (i % 6 == 0) rb = ~ra;
      if (i % 6 == 1) rb = ra;
      check_op($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Multi-precision sequential adder/subtractor. It accepts wide operands over a valid/ready handshake and adds them one 16-bit chunk per cycle, least significant chunk first, through a single 16-bit carry-lookahead adder, chaining the carry through a register. Wide results go downstream over a second valid/ready handshake. The block sits directly around the 16-bit adder datapath: it feeds the adder its operands and consumes the adder's sum and carry.

## Interface
Parameters:
- W, 16, chunk width; fixed to the adder width.
- WORDS, 4, number of chunks; operand width N = W*WORDS; legal range 2..8.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  N  operand A, unsigned or two's complement.
- b  input  N  operand B.
- cin  input  1  carry-in for an add; ignored when op_sub=1.
- op_sub  input  1  0 computes a+b+cin; 1 computes a-b.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- sum  output  N  result, registered.
- cout  output  1  carry out of bit N-1; for a subtract, 1 means no borrow.
- ovf  output  1  signed overflow of the N-bit operation.

## Operation
- States are IDLE, RUN and DONE, with a chunk index idx of width clog2(WORDS).
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, the block latches a, b and op_sub.
  - Initial carry is 1 if op_sub=1, otherwise cin.
  - Next state is RUN with idx=0.
- RUN, at each edge:
  - The adder takes the a chunk [idx*W +: W], the b chunk (inverted if op_sub), and the carry register.
  - Its sum is written to sum[idx*W +: W] and its carry out to the carry register.
  - idx increments.
  - On the edge that processes idx=WORDS-1, the block also registers cout and ovf and goes to DONE.
- ovf = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]), where b_eff is b or ~b.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are held stable.
  - On out_valid&out_ready the block goes to IDLE.
- in_valid while not IDLE is ignored. The operand inputs need only be stable on the accept edge.
- Chunk arithmetic is exactly W bits plus carry. There is no saturation; wrap-around is modulo 2^N.

## Timing
- Reset values, asynchronous: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry register=0, idx=0.
- Latency: out_valid rises WORDS edges after the accept edge. With WORDS=4, accept at edge 0 gives out_valid high after edge 4.
- in_ready returns high in the cycle after the out handshake edge. Input and output handshakes never overlap, so there is no bypass.
- Maximum throughput is one operation per WORDS+2 cycles when out_ready is held high.
- Backpressure: DONE holds indefinitely while out_ready=0, with all outputs constant.
- Reset asserted mid-RUN or mid-DONE aborts the operation. Outputs take their reset values immediately, and a partial sum is never presented.
- sum bits of chunks not yet processed keep their prior values during RUN. Downstream must use sum only when out_valid=1.

## Structure
- Package mp_add_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the constant CHUNK_W=16;
  - a function computing the index width from WORDS.
- One sub-module, cla_add16: a purely combinational 16-bit carry-lookahead adder.
  - Inputs a, b, cin; outputs sum and cout.
  - Each c[i+1] = g[i] | p[i]&c[i], fully expanded.
  - cout = c16; sum[i] = p[i]^c[i] for all 16 bits including bit 15.
- mp_add_seq instantiates cla_add16 once and owns the FSM, index, carry register and result registers.

## Test plan
All scenarios use WORDS=4 (N=64).
- Add with carry across chunks: a=0x0000_0000_0000_FFFF, b=0x1, cin=0 -> sum=0x0000_0000_0001_0000, cout=0, ovf=0; out_valid high exactly 4 edges after accept.
- Full wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0, cout=1, ovf=0. Also add with cin=1 and b=0 -> same result.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- Subtract with borrow: a=5, b=10, op_sub=1, cin=1 (ignored) -> sum=0xFFFF_FFFF_FFFF_FFFB, cout=0, ovf=0. Then a=10, b=5 -> sum=5, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands -> outputs unchanged, in_ready=0, new operands not taken. Release out_ready -> in_ready high the next cycle.
- Reset mid-RUN after 2 chunks -> out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 immediately. The next operation (1000+2001) returns sum=3001 with correct latency.
